// File: rtl/acm_in_packer.sv
// acm_in_packer: byte FIFO in front of the muacm IN pipe. It closes USB IN
// packets with in_last at MAX_PKT bytes, or on the last buffered byte once
// writes have been idle for IDLE_CYCLES. If the FIFO has already drained
// when idle matures, it asks muacm to close the partial packet with a
// one-cycle in_flush_now.
module acm_in_packer #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned MAX_PKT     = 64,
  parameter int unsigned IDLE_CYCLES = 4800
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               in_data,
  output logic                     in_last,
  output logic                     in_valid,
  input  logic                     in_ready,
  output logic                     in_flush_now,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int unsigned IW = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [PW-1:0] PKT_END  = PW'(MAX_PKT - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [PW-1:0] r_pkt_cnt;
  logic [IW-1:0] r_idle_cnt;
  logic          r_flush;

  logic w_wr;
  logic w_rd;
  logic w_idle;
  logic w_last;
  logic w_flush_nxt;

  // Handshakes and packet-closure conditions, all derived from registered state.
  always_comb begin
    w_idle      = (r_idle_cnt == IDLE_MAX);
    w_wr        = wr_valid && (r_level < LVL_FULL);
    w_rd        = in_ready && (r_level != '0);
    w_last      = (r_level != '0) &&
                  ((r_pkt_cnt == PKT_END) || ((r_level == LVL_ONE) && w_idle));
    w_flush_nxt = (r_level == '0) && (r_pkt_cnt != '0) && w_idle &&
                  !w_wr && !r_flush;
  end

  assign wr_ready     = (r_level < LVL_FULL);
  assign in_valid     = (r_level != '0);
  assign in_data      = r_mem[r_rptr];
  assign in_last      = w_last;
  assign in_flush_now = r_flush;
  assign level        = r_level;

  // Storage array; deliberately not reset, nothing reads it while empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // Occupancy: unchanged when a read and a write coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Bytes already sent in the current IN packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pkt_cnt <= '0;
    end else if (r_flush) begin
      r_pkt_cnt <= '0;
    end else if (w_rd) begin
      if (w_last) begin
        r_pkt_cnt <= '0;
      end else begin
        r_pkt_cnt <= r_pkt_cnt + PW'(1);
      end
    end
  end

  // Write-idle timer; reset value is "already idle" so nothing is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= IDLE_MAX;
    end else if (w_wr) begin
      r_idle_cnt <= '0;
    end else if (!w_idle) begin
      r_idle_cnt <= r_idle_cnt + IW'(1);
    end
  end

  // One-cycle flush request for a partial packet that drained before idle matured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_flush_nxt;
    end
  end

endmodule

// File: tb/tb_acm_in_packer.sv
// Directed bench for acm_in_packer: scoreboard of expected bytes/last flags
// filled on accepted writes and drained on IN-pipe handshakes.
module tb_acm_in_packer;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned MAX_PKT = 64;
  localparam int unsigned IDLE    = 300;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic          in_flush_now;
  logic [LW-1:0] level;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;
  int unsigned wr_cyc = 0;
  int unsigned last_pop_cyc = 0;
  int          flush_cnt = 0;
  logic        band = 1'b0;

  acm_in_packer #(
    .DEPTH       (DEPTH),
    .MAX_PKT     (MAX_PKT),
    .IDLE_CYCLES (IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flush_now (in_flush_now),
    .level        (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IN-pipe monitor: pops the scoreboard on every handshake, counts flushes.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_flush_now) flush_cnt++;
      if (band) chk("full_level_band", 32'((level >= LW'(63)) && (level <= LW'(64))), 32'd1);
      if (in_valid && in_ready) begin
        last_pop_cyc = cyc_cnt;
        if (sb.size() == 0) begin
          chk("rd_unexpected", 32'(in_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_data", 32'(in_data), 32'(e.data));
          chk("rd_last", 32'(in_last), 32'(e.last));
        end
      end
    end
  end

  // Offer one byte and hold wr_valid until accepted (bounded); wr_valid stays high on return.
  task automatic wr_byte(input logic [7:0] d, input logic exp_last);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (wr_ready) begin
        acc = 1'b1;
        wr_cyc = cyc_cnt;
        sb.push_back('{last: exp_last, data: d});
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("wr_accept_timeout", 32'(acc), 32'd1);
  endtask

  // Count negedges until in_last rises (bounded) and compare the delay.
  task automatic wait_last(input string tag, input int exp_n);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < exp_n + 50) begin
      @(negedge clk);
      n++;
      if (in_last) seen = 1'b1;
    end
    chk({tag, "_last_delay"}, 32'(n), 32'(exp_n));
  endtask

  // Wait (bounded) for the FIFO to drain, then check nothing is outstanding.
  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (level != '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 32'(level), 32'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int f0;
    int fn;
    int vcnt;
    int unsigned a;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; in_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_in_last", 32'(in_last), 32'd0);
    chk("rst_flush", 32'(in_flush_now), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three bytes; the last one waits with in_ready low until idle closes it.
    in_ready = 1'b1;
    f0 = flush_cnt;
    wr_byte(8'h41, 1'b0);
    a = wr_cyc;
    wr_byte(8'h42, 1'b0);
    chk("t1_first_latency", 32'(last_pop_cyc - a), 32'd1);
    wr_byte(8'h43, 1'b1);
    wr_valid = 1'b0;
    in_ready = 1'b0;
    wait_last("t1", IDLE + 1);
    chk("t1_data_held", 32'(in_data), 32'h43);
    @(posedge clk); #1;
    in_ready = 1'b1;
    drain("t1");
    chk("t1_no_flush", 32'(flush_cnt - f0), 32'd0);

    // 130 bytes streamed: MAX_PKT closure on 64 and 128, idle closure on 130.
    f0 = flush_cnt;
    for (int i = 1; i <= 130; i++) begin
      wr_byte(8'(i), (i % MAX_PKT == 0) || (i == 130));
      if (i == 130) in_ready = 1'b0;
    end
    wr_valid = 1'b0;
    wait_last("t2", IDLE + 1);
    @(posedge clk); #1;
    in_ready = 1'b1;
    drain("t2");
    chk("t2_no_flush", 32'(flush_cnt - f0), 32'd0);

    // Two bytes drain before idle; flush must fire once, one cycle after idle matures.
    f0 = flush_cnt;
    fn = 0;
    wr_byte(8'hA0, 1'b0);
    wr_byte(8'hA1, 1'b0);
    wr_valid = 1'b0;
    for (int n = 1; n <= int'(IDLE) + 40; n++) begin
      @(negedge clk);
      if (in_flush_now && fn == 0) fn = n;
    end
    chk("t3_flush_delay", 32'(fn), 32'(IDLE + 2));
    chk("t3_flush_count", 32'(flush_cnt - f0), 32'd1);
    chk("t3_pkt_cnt", 32'(dut.r_pkt_cnt), 32'd0);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Fill to DEPTH with the sink stalled; the 65th byte must be refused.
    in_ready = 1'b0;
    for (int i = 0; i < 64; i++) wr_byte(8'(8'h80 + i), i == 63);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_level_full", 32'(level), 32'd64);
    chk("t4_wr_ready_low", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    wr_data = 8'hEE;
    wr_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_refuse", 32'(wr_ready), 32'd0);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t4_level_hold", 32'(level), 32'd64);
    @(posedge clk); #1;
    in_ready = 1'b1;
    drain("t4");

    // Full FIFO with both sides active: level stays in 63..64, order preserved.
    in_ready = 1'b0;
    for (int i = 0; i < 64; i++) wr_byte(8'(i), (i % MAX_PKT) == MAX_PKT - 1);
    in_ready = 1'b1;
    band = 1'b1;
    for (int i = 64; i < 128; i++) wr_byte(8'(i), (i % MAX_PKT) == MAX_PKT - 1);
    wr_valid = 1'b0;
    band = 1'b0;
    drain("t5");

    // Reset mid-packet with level=10, pkt_cnt=5: everything discarded, no flush later.
    for (int i = 0; i < 5; i++) wr_byte(8'(8'h10 + i), 1'b0);
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_ready = 1'b0;
    for (int i = 0; i < 10; i++) wr_byte(8'(8'h20 + i), 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    chk("t6_level_pre", 32'(level), 32'd10);
    chk("t6_pkt_cnt_pre", 32'(dut.r_pkt_cnt), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_in_valid", 32'(in_valid), 32'd0);
    chk("t6_rst_in_last", 32'(in_last), 32'd0);
    chk("t6_rst_flush", 32'(in_flush_now), 32'd0);
    chk("t6_rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("t6_rst_level", 32'(level), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    in_ready = 1'b1;
    f0 = flush_cnt;
    vcnt = 0;
    repeat (IDLE + 20) begin
      @(negedge clk);
      if (in_valid) vcnt++;
    end
    chk("t6_no_valid_after", 32'(vcnt), 32'd0);
    chk("t6_no_flush_after", 32'(flush_cnt - f0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
